// File: rtl/freq_meter_pkg.sv
// Shared definitions for the toggle period meter: sizing helpers, FSM state type, timeout multiplier.
// Latency: n/a (compile-time constants and types only).
// Backpressure: n/a.
package freq_meter_pkg;

    // The timeout fires after TIMEOUT_MULT expected periods, minus one count.
    localparam int TIMEOUT_MULT = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } meter_state_t;

    // Smallest r with 2**r >= value (value >= 1).
    function automatic int ceil_log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Expected period of the measured signal in base-clock cycles.
    function automatic int period_count(input int base_clk, input int target_freq);
        return base_clk / target_freq;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Rising-edge detector with optional two-flop synchronizer (macro SYNC_INPUT_EN).
// Latency: rise is combinational from the (synchronized) input; the synchronizer adds 2 cycles.
// Backpressure: none; rise is a single-cycle pulse that is never held.
//
// Ports: clk, reset (async active-high), sig_in (raw input), rise (one-cycle pulse).
module edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    output logic rise
);
    logic s;
    logic s_d;

`ifdef SYNC_INPUT_EN
    logic sync_q1;
    logic sync_q2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= sig_in;
            sync_q2 <= sync_q1;
        end
    end

    assign s = sync_q2;
`else
    // Only valid for sources already synchronous to clk.
    assign s = sig_in;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_d <= 1'b0;
        end else begin
            s_d <= s;
        end
    end

    assign rise = s & ~s_d;

endmodule

// File: rtl/toggle_period_meter.sv
// Measures the period of sig_in in clk cycles, flags tolerance, lock and timeout.
// Latency: period_valid 1 cycle after the sampled rising edge (3 with SYNC_INPUT_EN defined).
// Backpressure: none; period_valid is a one-cycle pulse and must be consumed when it fires.
//
// Ports: clk, reset (async active-high), enable, sig_in; outputs period_out,
// period_valid, in_range, lock, timeout (sticky until next reported period or disable).
// Configuration macro: SYNC_INPUT_EN adds a two-flop synchronizer on sig_in.
module toggle_period_meter
    import freq_meter_pkg::*;
#(
    parameter int  BASE_CLK          = 50000000,
    parameter int  TARGET_FREQUENCY  = 100000,
    parameter int  TOLERANCE         = 2,
    parameter int  LOCK_COUNT        = 4,
    localparam int EXPECTED_PERIOD   = period_count(BASE_CLK, TARGET_FREQUENCY),
    localparam int NBITS_FOR_COUNTER = ceil_log2(TIMEOUT_MULT * EXPECTED_PERIOD)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         sig_in,
    output logic [NBITS_FOR_COUNTER-1:0] period_out,
    output logic                         period_valid,
    output logic                         in_range,
    output logic                         lock,
    output logic                         timeout
);
    localparam int NB     = NBITS_FOR_COUNTER;
    localparam int LOCK_W = ceil_log2(LOCK_COUNT + 1);

    localparam logic [NB-1:0]        TIMEOUT_VALUE = NB'(TIMEOUT_MULT * EXPECTED_PERIOD - 1);
    localparam logic [NB-1:0]        CNT_ONE       = NB'(1);
    localparam logic signed [NB:0]   EXP_S         = (NB + 1)'(EXPECTED_PERIOD);
    localparam logic signed [NB:0]   TOL_S         = (NB + 1)'(TOLERANCE);
    localparam logic [LOCK_W-1:0]    LOCK_MAX      = LOCK_W'(LOCK_COUNT);
    localparam logic [LOCK_W-1:0]    LOCK_ONE      = LOCK_W'(1);

    meter_state_t        state, state_nxt;
    logic [NB-1:0]       count, count_nxt;
    logic [NB-1:0]       period_nxt;
    logic                valid_nxt;
    logic                in_range_nxt;
    logic                timeout_nxt;
    logic [LOCK_W-1:0]   lock_cnt, lock_cnt_nxt;

    logic                rise;
    logic [NB-1:0]       meas_period;
    logic signed [NB:0]  period_diff;
    logic                meas_in_range;

    edge_sync u_edge_sync (
        .clk    (clk),
        .reset  (reset),
        .sig_in (sig_in),
        .rise   (rise)
    );

    // count holds (cycles since last rise - 1), so the period closed by this rise is count+1.
    // The counter never exceeds TIMEOUT_VALUE, so count+1 always fits in NB bits.
    assign meas_period   = count + CNT_ONE;
    // One extra bit keeps the signed difference from wrapping for any period value.
    assign period_diff   = $signed({1'b0, meas_period}) - EXP_S;
    assign meas_in_range = (period_diff <= TOL_S) && (period_diff >= -TOL_S);

    assign lock = (lock_cnt >= LOCK_MAX);

    always_comb begin
        state_nxt    = state;
        count_nxt    = count;
        period_nxt   = period_out;
        valid_nxt    = 1'b0;
        in_range_nxt = in_range;
        timeout_nxt  = timeout;
        lock_cnt_nxt = lock_cnt;

        if (!enable) begin
            // Disable overrides every state; a partially counted period is discarded.
            state_nxt    = IDLE;
            count_nxt    = '0;
            lock_cnt_nxt = '0;
            timeout_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = ARM;
                end
                ARM: begin
                    if (rise) begin
                        count_nxt = '0;
                        state_nxt = MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        // A rise at count==TIMEOUT_VALUE lands here too: the rise wins.
                        period_nxt   = meas_period;
                        count_nxt    = '0;
                        valid_nxt    = 1'b1;
                        in_range_nxt = meas_in_range;
                        timeout_nxt  = 1'b0;
                        if (meas_in_range) begin
                            if (lock_cnt < LOCK_MAX) begin
                                lock_cnt_nxt = lock_cnt + LOCK_ONE;
                            end
                        end else begin
                            lock_cnt_nxt = '0;
                        end
                    end else if (count == TIMEOUT_VALUE) begin
                        timeout_nxt  = 1'b1;
                        lock_cnt_nxt = '0;
                        state_nxt    = ARM;
                    end else begin
                        count_nxt = count + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            period_out   <= '0;
            period_valid <= 1'b0;
            in_range     <= 1'b0;
            timeout      <= 1'b0;
            lock_cnt     <= '0;
        end else begin
            state        <= state_nxt;
            count        <= count_nxt;
            period_out   <= period_nxt;
            period_valid <= valid_nxt;
            in_range     <= in_range_nxt;
            timeout      <= timeout_nxt;
            lock_cnt     <= lock_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_toggle_period_meter.sv
// Testbench for toggle_period_meter at default parameters (expected period 500, tolerance 2, lock 4).
// Latency: n/a.
// Backpressure: n/a.
module tb_toggle_period_meter;

`ifdef SYNC_INPUT_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    localparam int EXP_P = 500;
    localparam int TOL   = 2;
    localparam int LOCKN = 4;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       sig_in;
    logic [9:0] period_out;
    logic       period_valid;
    logic       in_range;
    logic       lock;
    logic       timeout;

    toggle_period_meter dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sig_in       (sig_in),
        .period_out   (period_out),
        .period_valid (period_valid),
        .in_range     (in_range),
        .lock         (lock),
        .timeout      (timeout)
    );

    typedef struct {
        int period;
        bit ir;
        bit lk;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   lk_run  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard consumer: every period_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (reset === 1'b0 && period_valid === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid: period_valid=1 period_out=%0d, required no report", period_out);
            end else begin
                mon_e = sb.pop_front();
                if (period_out !== 10'(mon_e.period)) begin
                    n_fail++;
                    $display("FAIL period_out: got %0d, expected %0d", period_out, mon_e.period);
                end
                n_tests++;
                if (in_range !== mon_e.ir) begin
                    n_fail++;
                    $display("FAIL in_range: got %b, expected %b (period %0d)", in_range, mon_e.ir, mon_e.period);
                end
                n_tests++;
                if (lock !== mon_e.lk) begin
                    n_fail++;
                    $display("FAIL lock_at_valid: got %b, expected %b (period %0d)", lock, mon_e.lk, mon_e.period);
                end
                n_tests++;
                if (timeout !== 1'b0) begin
                    n_fail++;
                    $display("FAIL timeout_at_valid: got %b, expected 0", timeout);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle high pulse; the rise is sampled at the next clock edge.
    task automatic rise_edge();
        sig_in = 1'b1;
        step();
        sig_in = 1'b0;
    endtask

    // Next rise sampled exactly n clk edges after the previous one.
    task automatic gap(input int n);
        repeat (n - 1) step();
        rise_edge();
    endtask

    task automatic push_exp(input int p);
        exp_t e;
        e.period = p;
        e.ir     = (p >= EXP_P - TOL) && (p <= EXP_P + TOL);
        if (e.ir) begin
            lk_run = (lk_run < LOCKN) ? lk_run + 1 : LOCKN;
        end else begin
            lk_run = 0;
        end
        e.lk = (lk_run >= LOCKN);
        sb.push_back(e);
    endtask

    task automatic expect_period(input int p);
        push_exp(p);
        gap(p);
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, got, want);
        end
    endtask

    task automatic check_all_zero(input string tag);
        n_tests++;
        if (period_out !== 10'd0) begin
            n_fail++;
            $display("FAIL %s_period_out: got %0d, expected 0", tag, period_out);
        end
        check_bit({tag, "_period_valid"}, period_valid, 1'b0);
        check_bit({tag, "_in_range"}, in_range, 1'b0);
        check_bit({tag, "_lock"}, lock, 1'b0);
        check_bit({tag, "_timeout"}, timeout, 1'b0);
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        enable = 1'b0;
        sig_in = 1'b0;
        #2 reset = 1'b1;
        #1 check_all_zero("reset");
        repeat (2) step();
        reset = 1'b0;
        step();
        check_all_zero("post_reset_disabled");
    endtask

    task automatic test_lock();
        enable = 1'b1;
        repeat (2) step();
        rise_edge();
        repeat (5) expect_period(EXP_P);
        check_bit("lock_after_5", lock, 1'b1);
        check_bit("timeout_after_5", timeout, 1'b0);
    endtask

    task automatic test_out_of_range();
        expect_period(503);
        repeat (4) expect_period(498);
        expect_period(502);
        expect_period(497);
    endtask

    task automatic test_timeout();
        repeat (4) expect_period(EXP_P);
        repeat (999 + SYNC_LAT) step();
        check_bit("timeout_before_999", timeout, 1'b0);
        check_bit("lock_before_999", lock, 1'b1);
        step();
        check_bit("timeout_at_999", timeout, 1'b1);
        check_bit("lock_at_999", lock, 1'b0);
        lk_run = 0;
        repeat (1200) step();
        check_bit("timeout_sticky", timeout, 1'b1);
        rise_edge();
        expect_period(EXP_P);
        // Rise coinciding with count==TIMEOUT_VALUE: reported, out of range, no timeout.
        expect_period(1000);
        expect_period(EXP_P);
    endtask

    task automatic test_enable_abort();
        repeat (4) expect_period(EXP_P);
        repeat (200) step();
        check_bit("lock_before_disable", lock, 1'b1);
        enable = 1'b0;
        step();
        check_bit("lock_after_disable", lock, 1'b0);
        check_bit("timeout_after_disable", timeout, 1'b0);
        repeat (299) step();
        rise_edge();
        repeat (10) step();
        enable = 1'b1;
        repeat (3) step();
        lk_run = 0;
        rise_edge();
        expect_period(EXP_P);
    endtask

    task automatic test_reset_mid();
        repeat (100) step();
        reset = 1'b1;
        #1 check_all_zero("mid_reset");
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        lk_run = 0;
        repeat (3) step();
        rise_edge();
        expect_period(EXP_P);
    endtask

    task automatic test_latency();
        int lat;
        bit seen;
        repeat (EXP_P - 1) step();
        push_exp(EXP_P);
        sig_in = 1'b1;
        lat    = 0;
        seen   = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (period_valid === 1'b1) seen = 1'b1;
        end
        sig_in = 1'b0;
        n_tests++;
        if (!seen || lat != 1 + SYNC_LAT) begin
            n_fail++;
            $display("FAIL latency: got %0d cycles (seen=%b), expected %0d", lat, seen, 1 + SYNC_LAT);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_lock();
        test_out_of_range();
        test_timeout();
        test_enable_abort();
        test_reset_mid();
        test_latency();
        repeat (10) step();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL missing_reports: got %0d outstanding, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/toggle_period_meter.md
# toggle_period_meter

Measures the period of an incoming square wave in base-clock cycles and checks it against an expected target frequency. It is the receive-side counterpart of the frequency-divider counter, which generates a flag at TARGET_FREQUENCY from BASE_CLK. This block takes that flag, or any slow periodic signal, and reports the measured period, whether it is within tolerance, a lock indication and a timeout. It sits between divider outputs and status/monitor logic.

## Interface
- BASE_CLK, 50000000: frequency of clk in Hz.
- TARGET_FREQUENCY, 100000: expected frequency of sig_in in Hz.
- TOLERANCE, 2: allowed absolute deviation of the measured period, in clk cycles.
- LOCK_COUNT, 4: consecutive in-range periods required to assert lock.
- EXPECTED_PERIOD, BASE_CLK/TARGET_FREQUENCY (500): derived; expected period in clk cycles.
- NBITS_FOR_COUNTER, CeilLog2(2*EXPECTED_PERIOD) (10): derived; width of the counter and of period_out.

Ports:
- clk, input, 1: the single clock.
- reset, input, 1: asynchronous, active-high reset.
- enable, input, 1: measurement enable.
- sig_in, input, 1: signal under measurement; may be asynchronous to clk.
- period_out, output, NBITS_FOR_COUNTER: last measured period in clk cycles.
- period_valid, output, 1: one-cycle pulse when period_out updates.
- in_range, output, 1: the last period satisfies |period_out − EXPECTED_PERIOD| ≤ TOLERANCE.
- lock, output, 1: LOCK_COUNT consecutive in-range periods have been seen.
- timeout, output, 1: sticky flag; no rising edge within TIMEOUT_VALUE = 2*EXPECTED_PERIOD−1 counts.

## Operation
- Reset: state IDLE; count, period_out, period_valid, in_range, lock, timeout, lock counter and edge-detect flops all 0.
- rise = s & ~s_d, where s is sig_in after the optional synchronizer and s_d is s delayed by one clock.
- States:
  - IDLE: entered whenever enable=0, regardless of state. Clears count, lock, lock counter and timeout. Holds period_out and in_range. Goes to ARM when enable=1.
  - ARM: waits for rise. On rise, count←0 and the state moves to MEASURE. No timeout is raised in ARM.
  - MEASURE: count increments each cycle. On rise:
    - period_out←count+1 and count←0.
    - period_valid pulses, and in_range is updated in the same cycle as the pulse.
    - timeout is cleared.
    - The state stays MEASURE.
- Timeout: in MEASURE, when count==TIMEOUT_VALUE and no rise occurs that cycle:
  - timeout←1, lock←0, lock counter←0, state←ARM.
  - period_out and in_range are held.
- Simultaneous rise with count==TIMEOUT_VALUE: the rise wins. period_out=2*EXPECTED_PERIOD, in_range=0, no timeout.
- Lock counter, width CeilLog2(LOCK_COUNT+1), saturating:
  - An in-range period increments it.
  - An out-of-range period clears it and clears lock.
  - lock=1 while the counter ≥ LOCK_COUNT.
- Range arithmetic: the difference is computed at NBITS_FOR_COUNTER+1 bits, signed; no wrap.

## Timing
- Period definition: rising edges on sig_in spaced N clk cycles apart yield period_out=N.
- Latency from the sig_in rising edge (sampled at a clk edge) to period_valid is:
  - 1 cycle without the synchronizer;
  - 3 cycles with it.
- lock rises in the same cycle as the LOCK_COUNT-th in-range period_valid.
- enable falling: IDLE takes effect on the next clk edge. Any edge in progress is discarded.
- Asynchronous reset mid-measurement forces all outputs to 0 immediately; no partial period is reported afterwards.

## Configuration
- SYNC_INPUT_EN defined: sig_in passes through a two-flop synchronizer before edge detection. This adds 2 cycles of latency; measured periods are unchanged.
- SYNC_INPUT_EN undefined: sig_in feeds the edge detector directly. This is only for synchronous sources such as the divider flag on the same clk.

## Structure
- Package freq_meter_pkg holds:
  - the CeilLog2 and period-count functions (BASE_CLK/TARGET_FREQUENCY);
  - the state enum typedef (IDLE, ARM, MEASURE);
  - the timeout-multiplier constant (2).
- Sub-module edge_sync holds the optional synchronizer and the rise detector. Its output is a single-cycle rise pulse.
- The top level holds the FSM, the period counter, the range compare and the lock counter.

## Test plan
- enable=1 with sig_in rising every 500 clks, default parameters:
  - period_valid pulses every 500 clks with period_out=500 and in_range=1;
  - lock=1 at the 4th pulse;
  - timeout stays 0.
- After lock, one period of 503 clks: period_out=503, in_range=0, lock falls in the same cycle. Four further 498-clk periods re-assert lock.
- sig_in stuck low after lock: timeout=1 and lock=0 exactly 999 counts after the last rise. The next two edges 500 clks apart clear timeout and report 500.
- enable dropped mid-period (count≈200) and restored: no period_valid for the aborted period. The first report after re-arm is the true 500. lock restarts from 0.
- reset asserted mid-MEASURE for 3 cycles: all outputs 0 immediately. After release, nothing is reported until two rises have been seen.
- Latency from a sig_in edge to period_valid: 1 cycle with SYNC_INPUT_EN undefined, 3 cycles with it defined. period_out=500 in both builds.
